// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller driving a 256x8 program/data memory.
// Optional macro CPU_SEQ_STEP_EN adds a single-step gate on instruction fetch.
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
`ifdef CPU_SEQ_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] mem_addr,
  output logic       mem_write,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] pc,
  output logic [7:0] acc_a,
  output logic [7:0] acc_b,
  output logic       carry,
  output logic       zero,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPERAND, S_MEMACC, S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_LDA  = 3'd2;
  localparam logic [2:0] OP_LDB  = 3'd3;
  localparam logic [2:0] OP_STR  = 3'd4;
  localparam logic [2:0] OP_LDM  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t     state, state_n;
  // Only the opcode field of IR is kept; the low five bits carry no meaning.
  logic [2:0] ir_op, ir_op_n;
  logic [7:0] opnd, opnd_n;
  logic [7:0] pc_n, a_n, b_n;
  logic       c_n, z_n;
  logic [8:0] alu;
  logic       fetch_go;

`ifdef CPU_SEQ_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir_op <= 3'd0;
      opnd  <= 8'h00;
      acc_a <= 8'h00;
      acc_b <= 8'h00;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir_op <= ir_op_n;
      opnd  <= opnd_n;
      acc_a <= a_n;
      acc_b <= b_n;
      carry <= c_n;
      zero  <= z_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_op_n = ir_op;
    opnd_n  = opnd;
    a_n     = acc_a;
    b_n     = acc_b;
    c_n     = carry;
    z_n     = zero;
    alu     = 9'h000;
    case (state)
      S_FETCH: if (fetch_go) begin
        ir_op_n = mem_rdata[7:5];
        pc_n    = pc + 8'd1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        case (ir_op)
          OP_ADD, OP_SUB: begin
            // 9-bit result: bit 8 is carry for ADD and borrow for SUB.
            alu     = (ir_op == OP_ADD) ? ({1'b0, acc_a} + {1'b0, acc_b})
                                        : ({1'b0, acc_a} - {1'b0, acc_b});
            a_n     = alu[7:0];
            c_n     = alu[8];
            z_n     = (alu[7:0] == 8'h00);
            state_n = S_FETCH;
          end
          OP_HALT: state_n = S_HALT;
          default: state_n = S_OPERAND;
        endcase
      end
      S_OPERAND: begin
        pc_n    = pc + 8'd1;
        opnd_n  = mem_rdata;
        state_n = S_FETCH;
        case (ir_op)
          OP_LDA:         a_n     = mem_rdata;
          OP_LDB:         b_n     = mem_rdata;
          OP_JMP:         pc_n    = mem_rdata;
          OP_STR, OP_LDM: state_n = S_MEMACC;
          default:        state_n = S_FETCH;
        endcase
      end
      S_MEMACC: begin
        if (ir_op == OP_LDM) a_n = mem_rdata;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Memory-side outputs depend on state and registers only, never on mem_rdata.
  always_comb begin
    mem_addr  = (state == S_MEMACC) ? opnd : pc;
    mem_write = (state == S_MEMACC) && (ir_op == OP_STR);
    mem_wdata = mem_write ? acc_a : 8'h00;
    halted    = (state == S_HALT);
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level model compared every cycle,
// plus directed programs with hand-computed results.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

`ifdef CPU_SEQ_STEP_EN
  logic step = 1'b1;
`endif

  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc, acc_a, acc_b;
  logic       mem_write, carry, zero, halted;

  cpu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CPU_SEQ_STEP_EN
    .step      (step),
`endif
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .acc_a     (acc_a),
    .acc_b     (acc_b),
    .carry     (carry),
    .zero      (zero),
    .halted    (halted)
  );

  logic [7:0] mem [256];
  logic [7:0] mm  [256];
  logic       clr = 1'b0, ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
  int tests = 0, fails = 0;
  int edge_cnt = 0, wr_cnt = 0, wr_edge = 0;

  assign mem_rdata = mem[mem_addr];

  // Memory: loads happen only while the DUT is held in reset.
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    else if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt = 0;
    else edge_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: each instruction takes ilen() edges and its
  // architectural effect lands on its final edge.
  logic [7:0] m_pc, m_a, m_b;
  logic       m_c, m_z, m_halt, m_go;
  logic [2:0] m_op;
  int         cyc;
  logic [7:0] m_o;
  logic [8:0] m_s;

`ifdef CPU_SEQ_STEP_EN
  assign m_go = step;
`else
  assign m_go = 1'b1;
`endif

  function automatic int ilen(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd7: return 2;
      3'd4, 3'd5:       return 4;
      default:          return 3;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00;
      m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_op = 3'd0; cyc = 0;
      if (clr) for (int i = 0; i < 256; i++) mm[i] = 8'h00;
      else if (ld_en) mm[ld_addr] = ld_data;
    end else if (!m_halt) begin
      if (cyc == 0) begin
        if (m_go) begin m_op = mm[m_pc][7:5]; cyc = 1; end
      end else begin
        cyc++;
        if (cyc == ilen(m_op)) begin
          m_o = mm[m_pc + 8'd1];
          case (m_op)
            3'd0: begin m_s = m_a + m_b; m_a = m_s[7:0]; m_c = m_s[8];
                        m_z = (m_a == 0); m_pc = m_pc + 8'd1; end
            3'd1: begin m_c = (m_a < m_b); m_a = m_a - m_b;
                        m_z = (m_a == 0); m_pc = m_pc + 8'd1; end
            3'd2: begin m_a = m_o; m_pc = m_pc + 8'd2; end
            3'd3: begin m_b = m_o; m_pc = m_pc + 8'd2; end
            3'd4: begin mm[m_o] = m_a; m_pc = m_pc + 8'd2; end
            3'd5: begin m_a = mm[m_o]; m_pc = m_pc + 8'd2; end
            3'd6: m_pc = m_o;
            default: begin m_halt = 1'b1; m_pc = m_pc + 8'd1; end
          endcase
          cyc = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  logic [7:0] exp_pc;
  logic       exp_mw;
  always @(negedge clk) begin
    if (!reset) begin
      wr_cnt = 0; wr_edge = 0;
    end else begin
      // pc advances by one at fetch and one more at the operand fetch.
      exp_pc = (cyc == 0) ? m_pc : ((cyc < 3) ? m_pc + 8'd1 : m_pc + 8'd2);
      exp_mw = !m_halt && (cyc == 3) && (m_op == 3'd4);
      chk("cyc_pc", pc, exp_pc);
      chk("cyc_acc_a", acc_a, m_a);
      chk("cyc_acc_b", acc_b, m_b);
      chk("cyc_carry", carry, m_c);
      chk("cyc_zero", zero, m_z);
      chk("cyc_halted", halted, m_halt);
      chk("cyc_mem_write", mem_write, exp_mw);
      if (exp_mw) begin
        chk("cyc_wr_addr", mem_addr, mm[m_pc + 8'd1]);
        chk("cyc_wr_data", mem_wdata, m_a);
      end
      if (mem_write) begin wr_cnt++; wr_edge = edge_cnt + 1; end
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic start();
    reset = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_default();
    poke(8'h00, 8'h40); poke(8'h01, 8'h0A); poke(8'h02, 8'h60); poke(8'h03, 8'h05);
    poke(8'h04, 8'h00); poke(8'h05, 8'h80); poke(8'h06, 8'h08); poke(8'h07, 8'hE0);
  endtask

  initial begin
    @(negedge clk);

    // Default program: LDA #0A, LDB #05, ADD, STR @08, HALT
    start();
    load_default();
    chk("rst_pc", pc, 8'h00);
    chk("rst_acc_a", acc_a, 8'h00);
    chk("rst_flags", {carry, zero, halted}, 3'b000);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    reset = 1'b1;
    run(13);
    chk("t1_not_halted_13", halted, 1'b0);
    run(1);
    chk("t1_halted_14", halted, 1'b1);
    chk("t1_acc_a", acc_a, 8'h0F);
    chk("t1_acc_b", acc_b, 8'h05);
    chk("t1_carry_zero", {carry, zero}, 2'b00);
    chk("t1_mem8", mem[8], 8'h0F);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_wr_edge", wr_edge, 12);

    // Carry/zero from ADD, then borrow from SUB
    start();
    poke(8'h00, 8'h40); poke(8'h01, 8'hFF); poke(8'h02, 8'h60); poke(8'h03, 8'h01);
    poke(8'h04, 8'h00); poke(8'h05, 8'h60); poke(8'h06, 8'h01); poke(8'h07, 8'h20);
    poke(8'h08, 8'hE0);
    reset = 1'b1;
    run(8);
    chk("t2_add_a", acc_a, 8'h00);
    chk("t2_add_cz", {carry, zero}, 2'b11);
    run(5);
    chk("t2_sub_a", acc_a, 8'hFF);
    chk("t2_sub_cz", {carry, zero}, 2'b10);
    run(2);
    chk("t2_halted", halted, 1'b1);

    // JMP 0x10 to a HALT
    start();
    poke(8'h00, 8'hC0); poke(8'h01, 8'h10); poke(8'h10, 8'hE0);
    reset = 1'b1;
    run(3);
    chk("t3_pc", pc, 8'h10);
    chk("t3_not_halted", halted, 1'b0);
    run(2);
    chk("t3_halted", halted, 1'b1);
    chk("t3_no_write", wr_cnt, 0);

    // pc wrap: LDM at 0xFE with its operand at 0xFF
    start();
    poke(8'h00, 8'hC0); poke(8'h01, 8'hFE); poke(8'hFE, 8'hA0); poke(8'hFF, 8'h40);
    poke(8'h40, 8'h5A);
    reset = 1'b1;
    run(3);
    chk("t4_pc_fe", pc, 8'hFE);
    run(4);
    chk("t4_acc_a", acc_a, 8'h5A);
    chk("t4_pc_wrap", pc, 8'h00);
    chk("t4_fetch_addr", mem_addr, 8'h00);

    // Async reset during the STR strobe
    start();
    poke(8'h00, 8'h40); poke(8'h01, 8'h33); poke(8'h02, 8'h80); poke(8'h03, 8'h50);
    poke(8'h04, 8'hE0); poke(8'h50, 8'h77);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("t5_strobe", mem_write, 1'b1);
    chk("t5_strobe_addr", mem_addr, 8'h50);
    chk("t5_strobe_data", mem_wdata, 8'h33);
    reset = 1'b0;
    #1;
    chk("t5_rst_write", mem_write, 1'b0);
    chk("t5_rst_pc", pc, 8'h00);
    chk("t5_rst_acc_a", acc_a, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("t5_mem_kept", mem[8'h50], 8'h77);
    reset = 1'b1;
    run(7);
    chk("t5_mem_written", mem[8'h50], 8'h33);
    run(2);
    chk("t5_halted", halted, 1'b1);

`ifdef CPU_SEQ_STEP_EN
    // Single step: fetch frozen while step=0, one pulse runs one instruction
    start();
    load_default();
    step = 1'b0;
    reset = 1'b1;
    run(20);
    chk("st_pc_frozen", pc, 8'h00);
    chk("st_addr_frozen", mem_addr, 8'h00);
    chk("st_acc_a_frozen", acc_a, 8'h00);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    run(10);
    chk("st_acc_a", acc_a, 8'h0A);
    chk("st_pc", pc, 8'h02);
    chk("st_acc_b", acc_b, 8'h00);
    step = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
